periph_hs_rx_fifo: RTL and testbench
====================================

// Module: periph_hs_rx_fifo
// PURPOSE
//   Parametrised peripheral receive port for the CPU-to-peripheral 4-phase send/ack link.
//   Captures each dataInput word offered with send, acknowledges it and buffers it in a
//   DEPTH-entry FIFO that local peripheral logic drains through a show-ahead read port.
//   Successor to the 2-bit single-register peripheral FSM: adds width, buffering,
//   back-pressure when full, and optional input synchronisation of send.
// PARAMETERS
//   DATA_W      2  width of dataInput / rd_data
//   DEPTH       4  FIFO entries; power of 2, >= 2
//   SYNC_STAGES 2  flops on send before the FSM; 0 = send used directly (same clock domain)
// PORTS
//   clk1       in   1                  single clock, rising edge
//   rst1       in   1                  reset, asynchronous, active-low
//   send       in   1                  producer request; dataInput stable while high
//   dataInput  in   DATA_W             word offered by producer
//   ack        out  1                  registered acknowledge
//   rd_en      in   1                  consumer pop request
//   rd_data    out  DATA_W             FIFO head (valid when rd_valid)
//   rd_valid   out  1                  FIFO not empty
//   full       out  1                  count == DEPTH
//   count      out  $clog2(DEPTH+1)    entries held
// BEHAVIOUR
//   Reset (rst1=0, async): ack=0, count=0, full=0, rd_valid=0, rd_data=0, sync flops=0,
//     state=IDLE, pointers=0. Held while low; release is synchronous to next clk1 edge.
//   send_s = send delayed SYNC_STAGES flops (SYNC_STAGES=0: send_s = send).
//   FSM states:
//     IDLE: ack=0. If send_s=1 and full=0 at the edge: write dataInput at wr_ptr,
//           wr_ptr++, go ACK. If send_s=1 and full=1: stay IDLE (back-pressure; no ack).
//     ACK : ack=1. If send_s=0: go IDLE (ack=0 next cycle). Else stay ACK; no further write.
//   Exactly one FIFO write per send high phase; send must fall before the next word.
//   Latency: send high first sampled at edge t -> ack=1 after edge t+SYNC_STAGES;
//     send low first sampled at edge u -> ack=0 after edge u+SYNC_STAGES.
//   dataInput sampled unsynchronised at the write edge (protocol guarantees stability).
//   Read: rd_data = mem[rd_ptr] (show-ahead, combinational from registers).
//     rd_en=1 and rd_valid=1 at edge -> rd_ptr++. rd_en on empty ignored, no error.
//   Simultaneous write and pop: count unchanged, both pointers advance.
//   Full: write decision uses full as registered before the edge; a pop in the same cycle
//     does not allow that cycle's write; the write occurs on the following edge.
//   Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is separate, 0..DEPTH.
//   Reset mid-handshake: ack drops immediately, FIFO contents discarded; if send is still
//     high after release, it is treated as a new transfer (duplicate capture by design).
// TESTING
//   1 SYNC_STAGES=2, DATA_W=8: send=1, dataInput=8'hA5 at edge 0 -> ack=1 after edge 2,
//     count=1, rd_data=8'hA5; send=0 -> ack=0 two edges later.
//   2 DEPTH=4: 4 full handshakes with 1,2,3,4, no pops -> full=1, count=4; 5th send=1 ->
//     ack stays 0; single pop returns 1 -> ack rises next cycle, 5th word stored.
//   3 Write 8 words with interleaved pops (wrap twice) -> pop order exactly 1..8, count=0,
//     rd_valid=0 at end.
//   4 count=2, handshake write and rd_en=1 on same edge -> count stays 2, head advances.
//   5 rd_en=1 with empty FIFO for 3 cycles -> count=0, pointers unchanged, rd_data=0
//     after reset.
//   6 rst1=0 while ack=1, count=3 -> ack, count, rd_valid 0 without clock edge; send held
//     high through release -> one new write, ack=1 after SYNC_STAGES+1 edges.

Source files
------------

// File: rtl/periph_hs_rx_fifo.sv
// Receive side of the CPU-to-peripheral 4-phase send/ack link.
// Each send high phase captures one word into a show-ahead FIFO drained by local logic.
module periph_hs_rx_fifo #(
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk1,
    input  logic                         rst1,
    input  logic                         send,
    input  logic [DATA_W-1:0]            dataInput,
    output logic                         ack,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               send_s;
    logic               wr_en;
    logic               pop;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [DATA_W-1:0]  mem [DEPTH];

    // Optional synchroniser chain on send; zero stages means same clock domain.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign send_s = send;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            always_ff @(posedge clk1 or negedge rst1) begin
                if (!rst1) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg[0] <= send;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_reg[i] <= sync_reg[i-1];
                    end
                end
            end
            assign send_s = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign rd_valid = (count_reg != '0);
    assign count    = count_reg;
    assign pop      = rd_en && rd_valid;
    assign ack      = (state_reg == ACK);

    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A full FIFO holds the FSM in IDLE, so the producer simply waits for ack.
    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (send_s && !full) begin
                    wr_en      = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!send_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= dataInput;
        end
    end

    // Head is masked while empty so stale storage never shows on rd_data.
    assign rd_data = rd_valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_periph_hs_rx_fifo.sv
// Scoreboard bench for periph_hs_rx_fifo: directed handshakes push expected words,
// a negedge monitor checks every popped head against the queue.
module tb_periph_hs_rx_fifo;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = $clog2(DEPTH+1);

    logic              clk1 = 1'b0;
    logic              rst1;
    logic              send;
    logic [DATA_W-1:0] dataInput;
    logic              ack;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic [CNT_W-1:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];

    periph_hs_rx_fifo #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk1      (clk1),
        .rst1      (rst1),
        .send      (send),
        .dataInput (dataInput),
        .ack       (ack),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .count     (count)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Monitor: every accepted pop must present the oldest expected word.
    always @(negedge clk1) begin
        if (rst1 === 1'b1 && rd_en === 1'b1 && rd_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got %0h expected none", rd_data);
            end else if (rd_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL pop_data: got %0h expected %0h", rd_data, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                $display("pop  %0h", rd_data);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_ack(input logic level, input string name);
        int k = 0;
        while (ack !== level && k < 20) begin
            tick();
            k++;
        end
        if (ack !== level) chk(name, {31'd0, ack}, {31'd0, level});
    endtask

    task automatic hs(input logic [DATA_W-1:0] w);
        dataInput = w;
        send      = 1'b1;
        exp_q.push_back(w);
        wait_ack(1'b1, "hs_ack_rise_timeout");
        send = 1'b0;
        wait_ack(1'b0, "hs_ack_fall_timeout");
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (rd_valid === 1'b1 && k < 2*DEPTH) begin
            pop1();
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1'b0; send = 1'b0; rd_en = 1'b0; dataInput = '0;
        repeat (3) tick();
        chk("rst_ack",      {31'd0, ack},      32'd0);
        chk("rst_count",    {29'd0, count},    32'd0);
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data",  {24'd0, rd_data},  32'd0);
        rst1 = 1'b1;
        tick();

        // 1: latency through two sync stages on rise and fall
        dataInput = 8'hA5; send = 1'b1; exp_q.push_back(8'hA5);
        tick(); chk("t1_ack_e0", {31'd0, ack}, 32'd0);
        tick(); chk("t1_ack_e1", {31'd0, ack}, 32'd0);
        tick(); chk("t1_ack_e2", {31'd0, ack}, 32'd1);
        chk("t1_count",   {29'd0, count},   32'd1);
        chk("t1_rd_data", {24'd0, rd_data}, 32'h A5);
        send = 1'b0;
        tick(); chk("t1_ackf_u0", {31'd0, ack}, 32'd1);
        tick(); chk("t1_ackf_u1", {31'd0, ack}, 32'd1);
        tick(); chk("t1_ackf_u2", {31'd0, ack}, 32'd0);
        pop1();
        chk("t1_count_end", {29'd0, count}, 32'd0);

        // 2: fill, back-pressure, release by a single pop
        for (int i = 1; i <= 4; i++) hs(8'(i));
        chk("t2_full",  {31'd0, full},  32'd1);
        chk("t2_count", {29'd0, count}, 32'd4);
        dataInput = 8'd5; send = 1'b1; exp_q.push_back(8'd5);
        repeat (6) tick();
        chk("t2_bp_ack",   {31'd0, ack},   32'd0);
        chk("t2_bp_count", {29'd0, count}, 32'd4);
        pop1();
        chk("t2_pop_ack",   {31'd0, ack},   32'd0);
        chk("t2_pop_count", {29'd0, count}, 32'd3);
        tick();
        chk("t2_late_ack",   {31'd0, ack},   32'd1);
        chk("t2_late_count", {29'd0, count}, 32'd4);
        send = 1'b0;
        wait_ack(1'b0, "t2_ack_fall_timeout");
        drain();

        // 3: eight words with interleaved pops, pointers wrap twice
        for (int i = 1; i <= 8; i++) begin
            hs(8'(i));
            if (i >= 2) pop1();
        end
        drain();
        chk("t3_count",    {29'd0, count},    32'd0);
        chk("t3_rd_valid", {31'd0, rd_valid}, 32'd0);

        // 4: write and pop on the same edge
        hs(8'd10); hs(8'd11);
        chk("t4_count_pre", {29'd0, count}, 32'd2);
        dataInput = 8'd12; send = 1'b1; exp_q.push_back(8'd12);
        tick(); tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t4_ack",     {31'd0, ack},     32'd1);
        chk("t4_count",   {29'd0, count},   32'd2);
        chk("t4_rd_data", {24'd0, rd_data}, 32'd11);
        send = 1'b0;
        wait_ack(1'b0, "t4_ack_fall_timeout");
        drain();

        // 5: pops on empty are ignored
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        chk("t5_count",    {29'd0, count},    32'd0);
        chk("t5_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("t5_rd_data",  {24'd0, rd_data},  32'd0);
        hs(8'd33);
        chk("t5_head", {24'd0, rd_data}, 32'd33);
        drain();

        // 6: reset mid-handshake, send held through release
        hs(8'h21); hs(8'h22);
        dataInput = 8'h23; send = 1'b1; exp_q.push_back(8'h23);
        wait_ack(1'b1, "t6_ack_rise_timeout");
        chk("t6_count_pre", {29'd0, count}, 32'd3);
        rst1 = 1'b0;
        #2;
        chk("t6_rst_ack",      {31'd0, ack},      32'd0);
        chk("t6_rst_count",    {29'd0, count},    32'd0);
        chk("t6_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        exp_q.delete();
        exp_q.push_back(8'h23);
        tick();
        rst1 = 1'b1;
        tick(); chk("t6_ack_r1", {31'd0, ack}, 32'd0);
        tick(); chk("t6_ack_r2", {31'd0, ack}, 32'd0);
        tick(); chk("t6_ack_r3", {31'd0, ack}, 32'd1);
        chk("t6_count_post", {29'd0, count}, 32'd1);
        send = 1'b0;
        wait_ack(1'b0, "t6_ack_fall_timeout");
        drain();
        chk("t6_count_end", {29'd0, count}, 32'd0);
        chk("sb_left", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
